// File: rtl/serial_sub_4bit_if.sv
// Operand/result bundle for the bit-serial subtractor.
// SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
interface serial_sub_4bit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   d;
  logic             busy;
  logic             done;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  d, busy, done
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_OVERFLOW_EN
    output ovf,
`endif
    output d, busy, done
  );
endinterface

// File: rtl/serial_sub_4bit.sv
// Bit-serial unsigned subtractor: d = {borrow, (a - b) mod 2^WIDTH}, LSB-first, one bit per clock.
// Optional feature macro: SUB_OVERFLOW_EN (adds the registered signed-overflow flag ovf).
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  serial_sub_4bit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             br_reg, br_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH:0]   d_reg, d_next;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb_reg, a_msb_next;
  logic             b_msb_reg, b_msb_next;
  logic             ovf_reg, ovf_next;
`endif

  logic accept;
  logic bit_a, bit_b, diff, br_calc;

  // Single full-subtractor cell fed from the LSBs of the operand shifters.
  assign bit_a   = sa_reg[0];
  assign bit_b   = sb_reg[0];
  assign diff    = bit_a ^ bit_b ^ br_reg;
  assign br_calc = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);

  assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      d_reg     <= '0;
`ifdef SUB_OVERFLOW_EN
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      res_reg   <= res_next;
      br_reg    <= br_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
`ifdef SUB_OVERFLOW_EN
      a_msb_reg <= a_msb_next;
      b_msb_reg <= b_msb_next;
      ovf_reg   <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    res_next   = res_reg;
    br_next    = br_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
`ifdef SUB_OVERFLOW_EN
    a_msb_next = a_msb_reg;
    b_msb_next = b_msb_reg;
    ovf_next   = ovf_reg;
`endif

    case (state_reg)
      RUN: begin
        res_next = {diff, res_reg[WIDTH-1:1]};
        sa_next  = {1'b0, sa_reg[WIDTH-1:1]};
        sb_next  = {1'b0, sb_reg[WIDTH-1:1]};
        br_next  = br_calc;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next = DONE;
          // The final diff bit is the result MSB; it never lands in res_reg.
          d_next     = {br_calc, diff, res_reg[WIDTH-1:1]};
`ifdef SUB_OVERFLOW_EN
          ovf_next   = (a_msb_reg != b_msb_reg) && (diff != a_msb_reg);
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Accept overrides the IDLE/DONE defaults; d is left untouched until completion.
    if (accept) begin
      state_next = RUN;
      sa_next    = bus.a;
      sb_next    = bus.b;
      res_next   = '0;
      br_next    = 1'b0;
      cnt_next   = '0;
`ifdef SUB_OVERFLOW_EN
      a_msb_next = bus.a[WIDTH-1];
      b_msb_next = bus.b[WIDTH-1];
`endif
    end
  end

  assign bus.d    = d_reg;
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf  = ovf_reg;
`endif
endmodule
